// File: rtl/mem_loader.sv
// Byte-stream memory loader: receives base address, word count and data words
// over an 8-bit handshake, and issues one 32-bit write per word to a memory responder.
module mem_loader #(
  parameter int MEM_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  output logic [MEM_W-1:0]   mem_wdata_o,
  input  logic               mem_rvalid_i,
  input  logic               mem_err_i,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    IDLE, ADDR, COUNT, DATA, REQ, WAIT, DONE, ERR
  } state_t;

  state_t      state, state_n;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] assembled;
  logic [31:0] base_addr;
  logic [31:0] word_count;
  logic [31:0] word_idx;
  logic [31:0] wait_cnt;
  logic        xfer;
  logic        last_byte;

  // Little-endian assembly: earlier bytes shift down, the current byte lands on top.
  assign assembled = {in_data, shift};
  assign xfer      = enable && in_valid && in_ready;
  assign last_byte = xfer && (byte_cnt == 2'd3);

  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:  state_n = ADDR;
        ADDR:  if (last_byte) state_n = (assembled[1:0] != 2'b00) ? ERR : COUNT;
        COUNT: if (last_byte) state_n = (assembled == '0) ? DONE : DATA;
        DATA:  if (last_byte) state_n = REQ;
        REQ:   state_n = WAIT;
        WAIT: begin
          if (mem_err_i)
            state_n = ERR;
          else if (mem_rvalid_i)
            state_n = (word_idx + 32'd1 == word_count) ? DONE : DATA;
          else if (wait_cnt == 32'(TIMEOUT - 1))
            state_n = ERR;
        end
        DONE:    state_n = DONE;
        ERR:     state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      byte_cnt    <= '0;
      shift       <= '0;
      base_addr   <= '0;
      word_count  <= '0;
      word_idx    <= '0;
      wait_cnt    <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == ADDR) || (state_n == COUNT) || (state_n == DATA);
      busy      <= !((state_n == IDLE) || (state_n == DONE) || (state_n == ERR));
      done      <= (state_n == DONE);
      error     <= (state_n == ERR);
      mem_req_o <= (state_n == REQ);
      mem_we_o  <= (state_n == REQ);
      mem_be_o  <= {(MEM_W/8){state_n == REQ}};

      if (state == IDLE) begin
        byte_cnt <= '0;
        word_idx <= '0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
      end

      if (xfer)
        shift <= assembled[31:8];

      if (last_byte && state == ADDR)
        base_addr <= assembled;
      if (last_byte && state == COUNT)
        word_count <= assembled;
      if (last_byte && state == DATA) begin
        mem_wdata_o <= assembled;
        mem_addr_o  <= base_addr + {word_idx[29:0], 2'b00};
      end

      if (state == WAIT && enable && mem_rvalid_i && !mem_err_i)
        word_idx <= word_idx + 32'd1;

      wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : '0;
    end
  end

endmodule
